// File: rtl/stdlatch_bank_pkg.sv
// stdlatch_bank_pkg: shared types and helpers for the latch bank.
// Holds the channel state enum, address-width derivation and even parity.
package stdlatch_bank_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_LOADED = 2'd1,
        ST_LOCKED = 2'd2
    } ch_state_e;

    // Address width for n channels; never narrower than one bit.
    function automatic int aw_of(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Even-parity bit: makes the total count of ones (data + bit) even.
    function automatic logic even_par(input logic [31:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/stdlatch_bank_cell.sv
// stdlatch_bank_cell: one channel of the bank (state, data, optional parity).
// Ports: clk, rst_n (sync active-low), pre_n (sync preset, active-low),
//        wr_hit, wr_lock, wr_data in; data, locked out.
//        With STDLATCH_BANK_PARITY_EN: par out (stored parity bit).
module stdlatch_bank_cell
    import stdlatch_bank_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] PRE_VAL = '1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pre_n,
    input  logic             wr_hit,
    input  logic             wr_lock,
    input  logic [WIDTH-1:0] wr_data,
`ifdef STDLATCH_BANK_PARITY_EN
    output logic             par,
`endif
    output logic [WIDTH-1:0] data,
    output logic             locked
);

    ch_state_e        state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;

    // Preset wins; a write only lands when the channel is not locked.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        unique case (1'b1)
            !pre_n: begin
                state_d = ST_EMPTY;
                data_d  = PRE_VAL;
            end
            (pre_n && wr_hit && (state_q != ST_LOCKED)): begin
                state_d = wr_lock ? ST_LOCKED : ST_LOADED;
                data_d  = wr_data;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            data_q  <= PRE_VAL;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

`ifdef STDLATCH_BANK_PARITY_EN
    logic par_q;

    always_ff @(posedge clk) begin
        if (!rst_n || !pre_n) begin
            par_q <= even_par(32'(PRE_VAL));
        end else if (wr_hit && (state_q != ST_LOCKED)) begin
            par_q <= even_par(32'(wr_data));
        end
    end

    assign par = par_q;
`endif

    assign data   = data_q;
    assign locked = (state_q == ST_LOCKED);

endmodule

// File: rtl/stdlatch_bank.sv
// stdlatch_bank: NCH x WIDTH holding-register bank with preset, write-lock
// and a one-cycle addressed read. Optional parity: STDLATCH_BANK_PARITY_EN.
// Ports: CLK, RST_N (sync active-low), PRE_N[NCH], WR_EN/WR_ADDR/WR_DATA/
//        WR_LOCK, RD_EN/RD_ADDR in; RD_DATA, RD_VALID, Q_ALL, LOCKED, ERR
//        out; RD_PERR out only when parity is enabled.
module stdlatch_bank
    import stdlatch_bank_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter int               NCH     = 4,
    parameter logic [WIDTH-1:0] PRE_VAL = '1,
    parameter int               AW      = aw_of(NCH)
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic [NCH-1:0]       PRE_N,
    input  logic                 WR_EN,
    input  logic [AW-1:0]        WR_ADDR,
    input  logic [WIDTH-1:0]     WR_DATA,
    input  logic                 WR_LOCK,
    input  logic                 RD_EN,
    input  logic [AW-1:0]        RD_ADDR,
    output logic [WIDTH-1:0]     RD_DATA,
    output logic                 RD_VALID,
    output logic [NCH*WIDTH-1:0] Q_ALL,
    output logic [NCH-1:0]       LOCKED,
`ifdef STDLATCH_BANK_PARITY_EN
    output logic                 RD_PERR,
`endif
    output logic                 ERR
);

    logic [WIDTH-1:0] ch_q [NCH];
    logic [NCH-1:0]   wr_hit;
    logic             wr_in_rng;
    logic             rd_in_rng;
    logic [WIDTH-1:0] rd_mux;
    logic             err_d;

    assign wr_in_rng = ({1'b0, WR_ADDR} < (AW+1)'(NCH));
    assign rd_in_rng = ({1'b0, RD_ADDR} < (AW+1)'(NCH));

`ifdef STDLATCH_BANK_PARITY_EN
    logic [NCH-1:0] ch_par;
    logic           rd_par;
    logic           perr_d;
`endif

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        assign wr_hit[i] = WR_EN && (WR_ADDR == AW'(i));

        stdlatch_bank_cell #(
            .WIDTH   (WIDTH),
            .PRE_VAL (PRE_VAL)
        ) u_cell (
            .clk     (CLK),
            .rst_n   (RST_N),
            .pre_n   (PRE_N[i]),
            .wr_hit  (wr_hit[i]),
            .wr_lock (WR_LOCK),
            .wr_data (WR_DATA),
`ifdef STDLATCH_BANK_PARITY_EN
            .par     (ch_par[i]),
`endif
            .data    (ch_q[i]),
            .locked  (LOCKED[i])
        );

        assign Q_ALL[i*WIDTH +: WIDTH] = ch_q[i];
    end

    // Loop mux keeps out-of-range addresses from indexing past the array.
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NCH; i++) begin
            if (RD_ADDR == AW'(i)) rd_mux = ch_q[i];
        end
    end

`ifdef STDLATCH_BANK_PARITY_EN
    always_comb begin
        rd_par = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (RD_ADDR == AW'(i)) rd_par = ch_par[i];
        end
    end

    assign perr_d = RD_EN && rd_in_rng &&
                    (even_par(32'(rd_mux)) != rd_par);
`endif

    // A preset on the target drops the write silently, so it cannot err.
    always_comb begin
        err_d = 1'b0;
        if (WR_EN && !wr_in_rng)       err_d = 1'b1;
        if (|(wr_hit & LOCKED & PRE_N)) err_d = 1'b1;
        if (RD_EN && !rd_in_rng)       err_d = 1'b1;
`ifdef STDLATCH_BANK_PARITY_EN
        if (perr_d)                    err_d = 1'b1;
`endif
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            RD_DATA  <= '0;
            RD_VALID <= 1'b0;
            ERR      <= 1'b0;
        end else begin
            RD_VALID <= RD_EN;
            ERR      <= err_d;
            if (RD_EN) RD_DATA <= rd_in_rng ? rd_mux : '0;
        end
    end

`ifdef STDLATCH_BANK_PARITY_EN
    always_ff @(posedge CLK) begin
        if (!RST_N) RD_PERR <= 1'b0;
        else        RD_PERR <= perr_d;
    end
`endif

endmodule

// File: tb/tb_stdlatch_bank.sv
// tb_stdlatch_bank: directed bench for stdlatch_bank (NCH=5, WIDTH=8)
// with a per-cycle reference model and literal spot checks.
module tb_stdlatch_bank;

    localparam int W  = 8;
    localparam int N  = 5;
    localparam int AW = 3;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   pre_n;
    logic           wr_en;
    logic [AW-1:0]  wr_addr;
    logic [W-1:0]   wr_data;
    logic           wr_lock;
    logic           rd_en;
    logic [AW-1:0]  rd_addr;
    logic [W-1:0]   rd_data;
    logic           rd_valid;
    logic [N*W-1:0] q_all;
    logic [N-1:0]   locked;
    logic           err;

    stdlatch_bank #(.WIDTH(W), .NCH(N)) dut (
        .CLK      (clk),
        .RST_N    (rst_n),
        .PRE_N    (pre_n),
        .WR_EN    (wr_en),
        .WR_ADDR  (wr_addr),
        .WR_DATA  (wr_data),
        .WR_LOCK  (wr_lock),
        .RD_EN    (rd_en),
        .RD_ADDR  (rd_addr),
        .RD_DATA  (rd_data),
        .RD_VALID (rd_valid),
        .Q_ALL    (q_all),
        .LOCKED   (locked),
        .ERR      (err)
    );

    always #5 clk = ~clk;

    // Reference model
    int       m_data [N];
    bit       m_lock [N];
    int       m_rd_data;
    bit       m_rd_valid;
    bit       m_err;
    bit       chk_en = 0;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [N*W-1:0] m_qall();
        logic [N*W-1:0] v;
        for (int i = 0; i < N; i++) v[i*W +: W] = W'(m_data[i]);
        return v;
    endfunction

    function automatic logic [N-1:0] m_locked();
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = m_lock[i];
        return v;
    endfunction

    // One clock: apply inputs, then advance the model by the same rules.
    task automatic step(input bit rst, input logic [N-1:0] pre,
                        input bit we, input int wa, input int wd,
                        input bit wl, input bit re, input int ra);
        @(negedge clk);
        rst_n = rst; pre_n = pre; wr_en = we; wr_addr = AW'(wa);
        wr_data = W'(wd); wr_lock = wl; rd_en = re; rd_addr = AW'(ra);
        @(posedge clk);
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                m_data[i] = 255; m_lock[i] = 0;
            end
            m_rd_data = 0; m_rd_valid = 0; m_err = 0;
        end else begin
            m_err = 0;
            m_rd_valid = re;
            if (re) m_rd_data = (ra < N) ? m_data[ra] : 0;
            if (re && ra >= N) m_err = 1;
            if (we && wa >= N) m_err = 1;
            for (int i = 0; i < N; i++) begin
                if (!pre[i]) begin
                    m_data[i] = 255; m_lock[i] = 0;
                end else if (we && wa == i) begin
                    if (m_lock[i]) m_err = 1;
                    else begin
                        m_data[i] = wd & 255; m_lock[i] = wl;
                    end
                end
            end
        end
        #1;
    endtask

    task automatic idle();
        step(1, '1, 0, 0, 0, 0, 0, 0);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("q_all",    64'(q_all),    64'(m_qall()));
            check("locked",   64'(locked),   64'(m_locked()));
            check("rd_valid", 64'(rd_valid), 64'(m_rd_valid));
            check("rd_data",  64'(rd_data),  64'(m_rd_data));
            check("err",      64'(err),      64'(m_err));
        end
    end

    initial begin
        rst_n = 0; pre_n = '1; wr_en = 0; wr_addr = '0; wr_data = '0;
        wr_lock = 0; rd_en = 0; rd_addr = '0;
        step(0, '1, 0, 0, 0, 0, 0, 0);
        step(0, '1, 0, 0, 0, 0, 0, 0);
        chk_en = 1;
        check("rst_qall",   64'(q_all),    64'h00FF_FFFF_FFFF);
        check("rst_locked", 64'(locked),   64'h0);
        check("rst_rdv",    64'(rd_valid), 64'h0);
        check("rst_err",    64'(err),      64'h0);

        idle();
        step(1, '1, 0, 0, 0, 0, 1, 2);
        check("rd2_data", 64'(rd_data),  64'hFF);
        check("rd2_vld",  64'(rd_valid), 64'h1);
        idle();
        check("rd2_vld0", 64'(rd_valid), 64'h0);
        check("rd2_hold", 64'(rd_data),  64'hFF);

        step(1, '1, 1, 1, 'h5A, 0, 0, 0);
        step(1, '1, 0, 0, 0, 0, 1, 1);
        check("rd1_5a", 64'(rd_data), 64'h5A);
        step(1, '1, 1, 1, 'h33, 0, 1, 1);
        check("rbw_5a", 64'(rd_data), 64'h5A);
        idle();
        check("ch1_33", 64'(q_all[15:8]), 64'h33);

        step(1, '1, 1, 3, 'hC3, 1, 0, 0);
        step(1, '1, 1, 3, 'h00, 0, 0, 0);
        check("lk_data", 64'(q_all[31:24]), 64'hC3);
        check("lk_lock", 64'(locked),       64'h08);
        check("lk_err",  64'(err),          64'h1);
        idle();
        check("lk_err0", 64'(err),          64'h0);

        step(1, 5'b10111, 1, 3, 'h11, 0, 0, 0);
        check("pre_data", 64'(q_all[31:24]), 64'hFF);
        check("pre_lock", 64'(locked),       64'h0);
        check("pre_err",  64'(err),          64'h0);

        step(1, '1, 1, 6, 'h77, 0, 1, 7);
        check("oor_rdd", 64'(rd_data),  64'h0);
        check("oor_vld", 64'(rd_valid), 64'h1);
        check("oor_err", 64'(err),      64'h1);
        check("oor_q",   64'(q_all),    64'h00FF_FFFF_33FF);

        // Mixed traffic over every channel, including lock and preset.
        for (int i = 0; i < N; i++)
            step(1, '1, 1, i, 'h10 + i * 'h11, (i == 4), 1, (i + 2) % N);
        for (int i = 0; i < N; i++)
            step(1, (i == 2) ? 5'b11011 : '1, 1, 4 - i, 'hA0 + i, 0, 1, i);
        step(1, 5'b01111, 1, 4, 'h99, 1, 1, 4);
        step(1, '1, 1, 4, 'h42, 1, 1, 4);
        step(1, '1, 1, 4, 'h43, 0, 1, 4);
        check("mix_ch4", 64'(q_all[39:32]), 64'h42);

        step(1, '1, 1, 0, 'hEE, 0, 0, 0);
        step(0, '1, 0, 0, 0, 0, 1, 0);
        check("rrst_vld", 64'(rd_valid), 64'h0);
        check("rrst_q",   64'(q_all),    64'h00FF_FFFF_FFFF);
        check("rrst_lk",  64'(locked),   64'h0);
        idle();
        idle();

        chk_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
